// File: rtl/fas_pkg.sv
// Shared definitions for the spectrum-analysis stage: frame geometry,
// FSM encoding and bin-word field helpers.
package fas_pkg;

  localparam int NBINS  = 16;
  localparam int NPAIRS = 8;
  localparam int DW     = 16;
  localparam int MAGW   = 32;
  localparam int BINW   = 2 * DW;
  localparam int IDXW   = 4;
  localparam int PW     = 3;

  localparam int RE_HI = 31;
  localparam int RE_LO = 16;
  localparam int IM_HI = 15;
  localparam int IM_LO = 0;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic logic signed [DW-1:0] bin_re(input logic [BINW-1:0] w);
    return w[RE_HI:RE_LO];
  endfunction

  function automatic logic signed [DW-1:0] bin_im(input logic [BINW-1:0] w);
    return w[IM_HI:IM_LO];
  endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// Combinational squared magnitude re^2 + im^2 of one complex bin.
module fft_mag_sq
  import fas_pkg::*;
(
  input  logic signed [DW-1:0] re_i,
  input  logic signed [DW-1:0] im_i,
  output logic [MAGW-1:0]      mag_o
);

  logic signed [MAGW-1:0] re_x;
  logic signed [MAGW-1:0] im_x;
  logic signed [MAGW-1:0] sq_re;
  logic signed [MAGW-1:0] sq_im;

  assign re_x  = {{(MAGW-DW){re_i[DW-1]}}, re_i};
  assign im_x  = {{(MAGW-DW){im_i[DW-1]}}, im_i};
  assign sq_re = re_x * re_x;
  assign sq_im = im_x * im_x;

  // Each square is at most 2^30, so the unsigned sum peaks at 2^31 and never wraps.
  assign mag_o = $unsigned(sq_re) + $unsigned(sq_im);

endmodule

// File: rtl/fft_analysis.sv
// Captures a 16-bin spectrum frame, scans it two bins per cycle and reports
// the index of the strongest bin with a one-cycle done pulse.
module fft_analysis
  import fas_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            fft_valid,
  input  logic [BINW-1:0] fft_d0,
  input  logic [BINW-1:0] fft_d1,
  input  logic [BINW-1:0] fft_d2,
  input  logic [BINW-1:0] fft_d3,
  input  logic [BINW-1:0] fft_d4,
  input  logic [BINW-1:0] fft_d5,
  input  logic [BINW-1:0] fft_d6,
  input  logic [BINW-1:0] fft_d7,
  input  logic [BINW-1:0] fft_d8,
  input  logic [BINW-1:0] fft_d9,
  input  logic [BINW-1:0] fft_d10,
  input  logic [BINW-1:0] fft_d11,
  input  logic [BINW-1:0] fft_d12,
  input  logic [BINW-1:0] fft_d13,
  input  logic [BINW-1:0] fft_d14,
  input  logic [BINW-1:0] fft_d15,
  output logic            done,
  output logic [IDXW-1:0] freq,
  output logic            overrun
);

  logic [BINW-1:0] din [NBINS];
  logic [BINW-1:0] buf_q [NBINS];

  state_t          state_q;
  logic [PW-1:0]   p_q;
  logic [MAGW-1:0] max_mag_q, max_mag_d;
  logic [IDXW-1:0] max_idx_q, max_idx_d;
  logic            done_q;
  logic [IDXW-1:0] freq_q;
  logic            overrun_q;

  logic            last_pair;
  logic            load_en;
  logic [IDXW-1:0] idx_even, idx_odd;
  logic [MAGW-1:0] mag_even, mag_odd;
  logic [MAGW-1:0] base_mag;
  logic [IDXW-1:0] base_idx;

  assign din[0]  = fft_d0;
  assign din[1]  = fft_d1;
  assign din[2]  = fft_d2;
  assign din[3]  = fft_d3;
  assign din[4]  = fft_d4;
  assign din[5]  = fft_d5;
  assign din[6]  = fft_d6;
  assign din[7]  = fft_d7;
  assign din[8]  = fft_d8;
  assign din[9]  = fft_d9;
  assign din[10] = fft_d10;
  assign din[11] = fft_d11;
  assign din[12] = fft_d12;
  assign din[13] = fft_d13;
  assign din[14] = fft_d14;
  assign din[15] = fft_d15;

  assign last_pair = (state_q == SCAN) && (p_q == PW'(NPAIRS - 1));
  // A frame arriving on the last pair is safe: pair 7 reads the old buffer this cycle.
  assign load_en   = fft_valid && ((state_q == IDLE) || last_pair);

  genvar gi;
  generate
    for (gi = 0; gi < NBINS; gi++) begin : g_buf
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          buf_q[gi] <= '0;
        end else if (load_en) begin
          buf_q[gi] <= din[gi];
        end
      end
    end
  endgenerate

  assign idx_even = {p_q, 1'b0};
  assign idx_odd  = {p_q, 1'b1};

  fft_mag_sq u_mag_even (
    .re_i  (bin_re(buf_q[idx_even])),
    .im_i  (bin_im(buf_q[idx_even])),
    .mag_o (mag_even)
  );

  fft_mag_sq u_mag_odd (
    .re_i  (bin_re(buf_q[idx_odd])),
    .im_i  (bin_im(buf_q[idx_odd])),
    .mag_o (mag_odd)
  );

  // Strict greater-than in ascending bin order keeps ties on the lowest index.
  always_comb begin
    base_mag = max_mag_q;
    base_idx = max_idx_q;
    if (p_q == '0) begin
      base_mag = mag_even;
      base_idx = idx_even;
    end else if (mag_even > max_mag_q) begin
      base_mag = mag_even;
      base_idx = idx_even;
    end
    max_mag_d = base_mag;
    max_idx_d = base_idx;
    if (mag_odd > base_mag) begin
      max_mag_d = mag_odd;
      max_idx_d = idx_odd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      p_q       <= '0;
      max_mag_q <= '0;
      max_idx_q <= '0;
      done_q    <= 1'b0;
      freq_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fft_valid) begin
            state_q <= SCAN;
            p_q     <= '0;
          end
        end
        SCAN: begin
          max_mag_q <= max_mag_d;
          max_idx_q <= max_idx_d;
          if (last_pair) begin
            done_q  <= 1'b1;
            freq_q  <= max_idx_d;
            p_q     <= '0;
            state_q <= fft_valid ? SCAN : IDLE;
          end else begin
            p_q <= p_q + 1'b1;
            if (fft_valid) begin
              overrun_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done    = done_q;
  assign freq    = freq_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_fft_analysis.sv
// Directed bench for fft_analysis: inputs driven and outputs sampled on the falling edge.
module tb_fft_analysis;

  logic        clk;
  logic        rst;
  logic        fft_valid;
  logic [31:0] frame [16];
  logic        done;
  logic [3:0]  freq;
  logic        overrun;

  int tests_run;
  int tests_failed;
  int done_count;

  fft_analysis dut (
    .clk       (clk),
    .rst       (rst),
    .fft_valid (fft_valid),
    .fft_d0    (frame[0]),
    .fft_d1    (frame[1]),
    .fft_d2    (frame[2]),
    .fft_d3    (frame[3]),
    .fft_d4    (frame[4]),
    .fft_d5    (frame[5]),
    .fft_d6    (frame[6]),
    .fft_d7    (frame[7]),
    .fft_d8    (frame[8]),
    .fft_d9    (frame[9]),
    .fft_d10   (frame[10]),
    .fft_d11   (frame[11]),
    .fft_d12   (frame[12]),
    .fft_d13   (frame[13]),
    .fft_d14   (frame[14]),
    .fft_d15   (frame[15]),
    .done      (done),
    .freq      (freq),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic fill(input logic [31:0] w);
    for (int i = 0; i < 16; i++) frame[i] = w;
  endtask

  task automatic peak_frame(input int bin);
    fill(32'h0);
    frame[bin] = 32'h1000_0000;
  endtask

  // Pulse fft_valid at k=0 and check done low at k=8, high with freq at k=9, low at k=10.
  task automatic run_frame(input string tag, input logic [3:0] exp_freq);
    fft_valid = 1'b1;
    tick();
    fft_valid = 1'b0;
    repeat (7) tick();
    check({tag, "_done_k8"}, 32'(done), 32'd0);
    tick();
    check({tag, "_done_k9"}, 32'(done), 32'd1);
    check({tag, "_freq_k9"}, 32'(freq), 32'(exp_freq));
    tick();
    check({tag, "_done_k10"}, 32'(done), 32'd0);
    check({tag, "_freq_hold"}, 32'(freq), 32'(exp_freq));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    fft_valid    = 1'b0;
    fill(32'h0);
    repeat (3) tick();
    check("reset_done", 32'(done), 32'd0);
    check("reset_freq", 32'(freq), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick();

    // Single tone in bin 5
    fill(32'h0);
    frame[5] = 32'h0100_0000;
    run_frame("tone5", 4'd5);

    // Tie between bins 3 and 11 over a {1,1} floor
    fill(32'h0001_0001);
    frame[3]  = 32'h0040_0040;
    frame[11] = 32'h0040_0040;
    run_frame("tie", 4'd3);

    // Extremes: (-32768,-32768) gives 2^31, above 32767^2
    fill(32'h0);
    frame[15] = 32'h8000_8000;
    frame[0]  = 32'h7FFF_0000;
    run_frame("extreme", 4'd15);

    // All-zero frame: every bin ties, lowest index wins
    fill(32'h0);
    run_frame("zeros", 4'd0);

    // Back-to-back frames at k=0, 8, 16
    peak_frame(2);
    fft_valid = 1'b1;
    tick();
    fft_valid = 1'b0;
    repeat (7) tick();
    check("b2b_done_k8", 32'(done), 32'd0);
    peak_frame(9);
    fft_valid = 1'b1;
    tick();
    fft_valid = 1'b0;
    check("b2b_done_k9", 32'(done), 32'd1);
    check("b2b_freq_k9", 32'(freq), 32'd2);
    repeat (7) tick();
    check("b2b_done_k16", 32'(done), 32'd0);
    peak_frame(14);
    fft_valid = 1'b1;
    tick();
    fft_valid = 1'b0;
    check("b2b_done_k17", 32'(done), 32'd1);
    check("b2b_freq_k17", 32'(freq), 32'd9);
    repeat (7) tick();
    check("b2b_done_k24", 32'(done), 32'd0);
    tick();
    check("b2b_done_k25", 32'(done), 32'd1);
    check("b2b_freq_k25", 32'(freq), 32'd14);
    tick();
    check("b2b_done_k26", 32'(done), 32'd0);
    check("b2b_overrun", 32'(overrun), 32'd0);

    // Overrun: second frame at k=4 is dropped
    peak_frame(7);
    fft_valid = 1'b1;
    tick();
    fft_valid = 1'b0;
    repeat (3) tick();
    check("ovr_before", 32'(overrun), 32'd0);
    peak_frame(1);
    fft_valid = 1'b1;
    tick();
    fft_valid = 1'b0;
    check("ovr_k5", 32'(overrun), 32'd1);
    repeat (3) tick();
    check("ovr_done_k8", 32'(done), 32'd0);
    tick();
    check("ovr_done_k9", 32'(done), 32'd1);
    check("ovr_freq_k9", 32'(freq), 32'd7);
    done_count = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) done_count++;
    end
    check("ovr_extra_done", 32'(done_count), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset mid-scan aborts the frame
    peak_frame(3);
    fft_valid = 1'b1;
    tick();
    fft_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("rst_async_freq", 32'(freq), 32'd0);
    check("rst_async_overrun", 32'(overrun), 32'd0);
    check("rst_async_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    done_count = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) done_count++;
    end
    check("rst_no_done", 32'(done_count), 32'd0);
    check("rst_freq_after", 32'(freq), 32'd0);

    // Recovery after reset
    peak_frame(6);
    run_frame("recover", 4'd6);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
